// File: rtl/sma_pkg.sv
// Shared types and constants for the moving-average filter chain.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sma_pkg;

    localparam int SMA_DATA_W = 16;
    localparam int SMA_OVF_W  = 16;

    typedef logic signed [SMA_DATA_W-1:0] sma_sample_t;

endpackage

// File: rtl/sma_fifo.sv
// Synchronous FIFO with extra-wrap-bit pointers, exposing full/empty/level.
// Latency: a write is visible at the head one edge later; head is combinational.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module sma_fifo
    import sma_pkg::*;
#(
    parameter int DATA_W = SMA_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    // Head reads as zero while empty so stale storage never leaks out.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards all buffered entries at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; when full with a simultaneous pop this overwrites the
    // slot being read out, which is safe because the read is combinational.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sma_decim.sv
// Keeps every DEC-th enabled filter sample and buffers it for a valid/ready consumer.
// Latency: sample taken at edge N appears on m_data after edge N when the buffer was empty.
// Backpressure: m_ready stalls drain; when the buffer is full new takes are dropped
// (counted in ovf_cnt when SMA_DECIM_OVF_EN is defined).
module sma_decim
    import sma_pkg::*;
#(
    parameter int DATA_W = SMA_DATA_W,
    parameter int DEC    = 2,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_W-1:0]    x_in,
    input  logic                        en,
    output logic signed [DATA_W-1:0]    m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(DEPTH):0]      level
`ifdef SMA_DECIM_OVF_EN
    ,
    output logic [SMA_OVF_W-1:0]        ovf_cnt
`endif
);

    localparam int              PH_W    = (DEC > 1) ? $clog2(DEC) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEC - 1);

    logic [PH_W-1:0]   ph;
    logic              take;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    // With DEC=1 the phase is pinned at 0 == PH_LAST, so every enabled sample is taken.
    assign take    = en && (ph == PH_LAST);
    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push    = take && (!full || pop);
    assign m_data  = head;

    // Phase advances on enabled samples only and wraps even when the take is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph <= '0;
        end else if (en) begin
            ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
        end
    end

    sma_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (x_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

`ifdef SMA_DECIM_OVF_EN
    logic drop;
    assign drop = take && full && !pop;

    // Saturating count of samples lost to a full buffer; cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sma_decim.sv
// Directed bench for sma_decim: one instance with DEC=2, one with DEC=1, both DEPTH=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Overflow-count checks are present only when SMA_DECIM_OVF_EN is defined.
module tb_sma_decim;
    import sma_pkg::*;

    logic        clk;
    logic        rst;

    sma_sample_t x2, d2;
    logic        en2, rdy2, v2;
    logic [3:0]  lvl2;

    sma_sample_t x1, d1;
    logic        en1, rdy1, v1;
    logic [3:0]  lvl1;

`ifdef SMA_DECIM_OVF_EN
    logic [15:0] ovf2, ovf1;
`endif

    int tests = 0;
    int fails = 0;

    sma_decim #(.DATA_W(16), .DEC(2), .DEPTH(8)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .x_in    (x2),
        .en      (en2),
        .m_data  (d2),
        .m_valid (v2),
        .m_ready (rdy2),
        .level   (lvl2)
`ifdef SMA_DECIM_OVF_EN
        ,
        .ovf_cnt (ovf2)
`endif
    );

    sma_decim #(.DATA_W(16), .DEC(1), .DEPTH(8)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .x_in    (x1),
        .en      (en1),
        .m_data  (d1),
        .m_valid (v1),
        .m_ready (rdy1),
        .level   (lvl1)
`ifdef SMA_DECIM_OVF_EN
        ,
        .ovf_cnt (ovf1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        x2 = 16'sd77; en2 = 1'b1; rdy2 = 1'b1;
        x1 = 16'sd55; en1 = 1'b1; rdy1 = 1'b1;
        #1;
        tests++;
        if (v2 !== 1'b0 || lvl2 !== 4'd0 || d2 !== 16'sd0) begin
            fails++;
            $display("FAIL reset_dut2: valid=%b level=%0d data=%0d, need 0/0/0", v2, lvl2, d2);
        end
        tests++;
        if (v1 !== 1'b0 || lvl1 !== 4'd0 || d1 !== 16'sd0) begin
            fails++;
            $display("FAIL reset_dut1: valid=%b level=%0d data=%0d, need 0/0/0", v1, lvl1, d1);
        end
`ifdef SMA_DECIM_OVF_EN
        tests++;
        if (ovf2 !== 16'd0 || ovf1 !== 16'd0) begin
            fails++;
            $display("FAIL reset_ovf: ovf2=%0d ovf1=%0d, need 0", ovf2, ovf1);
        end
`endif
        en2 = 1'b0; en1 = 1'b0; rdy2 = 1'b0; rdy1 = 1'b0;
        #10 rst = 1'b1;
    endtask

    // DEC=2, en always high: every second sample, each valid for one cycle.
    task automatic test_decimate();
        int exp_d [6];
        logic exp_v [6];
        exp_d = '{0, 2, 0, 4, 0, 6};
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        en2 = 1'b1; rdy2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x2 = sma_sample_t'(i + 1);
            step();
            tests++;
            if (v2 !== exp_v[i] || d2 !== sma_sample_t'(exp_d[i])) begin
                fails++;
                $display("FAIL decimate[%0d]: valid=%b data=%0d, need valid=%b data=%0d",
                         i, v2, d2, exp_v[i], exp_d[i]);
            end
        end
    endtask

    // Only enabled samples advance the phase: 12 and 15 are kept.
    task automatic test_enable_gating();
        logic en_seq [6];
        int   exp_d  [6];
        logic exp_v  [6];
        en_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_d  = '{0, 0, 12, 0, 0, 15};
        exp_v  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        rdy2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x2  = sma_sample_t'(10 + i);
            en2 = en_seq[i];
            step();
            tests++;
            if (v2 !== exp_v[i] || d2 !== sma_sample_t'(exp_d[i])) begin
                fails++;
                $display("FAIL enable_gating[%0d]: valid=%b data=%0d, need valid=%b data=%0d",
                         i, v2, d2, exp_v[i], exp_d[i]);
            end
        end
        en2 = 1'b0;
        step();
        tests++;
        if (v2 !== 1'b0 || lvl2 !== 4'd0) begin
            fails++;
            $display("FAIL enable_drain: valid=%b level=%0d, need 0/0", v2, lvl2);
        end
    endtask

    // DEC=1, consumer stalled: buffer fills at 8, two samples dropped, then drains in order.
    task automatic test_overflow();
        int exp_l [10];
        exp_l = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
        rdy1 = 1'b0; en1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x1 = sma_sample_t'(100 + i);
            step();
            tests++;
            if (lvl1 !== 4'(exp_l[i])) begin
                fails++;
                $display("FAIL ovf_fill[%0d]: level=%0d, need %0d", i, lvl1, exp_l[i]);
            end
        end
        tests++;
        if (v1 !== 1'b1 || d1 !== 16'sd100) begin
            fails++;
            $display("FAIL ovf_head: valid=%b data=%0d, need 1/100", v1, d1);
        end
`ifdef SMA_DECIM_OVF_EN
        tests++;
        if (ovf1 !== 16'd2) begin
            fails++;
            $display("FAIL ovf_count: ovf_cnt=%0d, need 2", ovf1);
        end
`endif
        en1 = 1'b0; rdy1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (v1 !== 1'b1 || d1 !== sma_sample_t'(100 + k) || lvl1 !== 4'(8 - k)) begin
                fails++;
                $display("FAIL ovf_drain[%0d]: valid=%b data=%0d level=%0d, need 1/%0d/%0d",
                         k, v1, d1, lvl1, 100 + k, 8 - k);
            end
            step();
        end
        tests++;
        if (v1 !== 1'b0 || lvl1 !== 4'd0 || d1 !== 16'sd0) begin
            fails++;
            $display("FAIL ovf_empty: valid=%b level=%0d data=%0d, need 0/0/0", v1, lvl1, d1);
        end
    endtask

    // Full buffer with take and pop together: push accepted, level stays 8.
    task automatic test_full_take_pop();
        rdy1 = 1'b0; en1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x1 = sma_sample_t'(200 + i);
            step();
        end
        tests++;
        if (lvl1 !== 4'd8) begin
            fails++;
            $display("FAIL full_level: level=%0d, need 8", lvl1);
        end
        x1 = 16'sd208; rdy1 = 1'b1;
        step();
        tests++;
        if (lvl1 !== 4'd8 || d1 !== 16'sd201) begin
            fails++;
            $display("FAIL full_take_pop: level=%0d data=%0d, need 8/201", lvl1, d1);
        end
`ifdef SMA_DECIM_OVF_EN
        tests++;
        if (ovf1 !== 16'd2) begin
            fails++;
            $display("FAIL full_take_pop_ovf: ovf_cnt=%0d, need 2", ovf1);
        end
`endif
        en1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (v1 !== 1'b1 || d1 !== sma_sample_t'(201 + k)) begin
                fails++;
                $display("FAIL full_drain[%0d]: valid=%b data=%0d, need 1/%0d", k, v1, d1, 201 + k);
            end
            step();
        end
        tests++;
        if (lvl1 !== 4'd0) begin
            fails++;
            $display("FAIL full_empty: level=%0d, need 0", lvl1);
        end
    endtask

    // Reset with 5 buffered entries and the phase mid-count.
    task automatic test_mid_reset();
        rdy2 = 1'b0; en2 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            x2 = sma_sample_t'(20 + i);
            step();
        end
        tests++;
        if (lvl2 !== 4'd5 || d2 !== 16'sd21) begin
            fails++;
            $display("FAIL midrst_fill: level=%0d data=%0d, need 5/21", lvl2, d2);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (v2 !== 1'b0 || lvl2 !== 4'd0 || d2 !== 16'sd0 || lvl1 !== 4'd0) begin
            fails++;
            $display("FAIL midrst_clear: valid=%b level=%0d data=%0d level1=%0d, need 0/0/0/0",
                     v2, lvl2, d2, lvl1);
        end
`ifdef SMA_DECIM_OVF_EN
        tests++;
        if (ovf1 !== 16'd0) begin
            fails++;
            $display("FAIL midrst_ovf: ovf_cnt=%0d, need 0", ovf1);
        end
`endif
        #2 rst = 1'b1;
        rdy2 = 1'b1; en2 = 1'b1;
        x2 = 16'sd40;
        step();
        tests++;
        if (v2 !== 1'b0) begin
            fails++;
            $display("FAIL midrst_first: valid=%b, need 0", v2);
        end
        x2 = 16'sd41;
        step();
        tests++;
        if (v2 !== 1'b1 || d2 !== 16'sd41) begin
            fails++;
            $display("FAIL midrst_second: valid=%b data=%0d, need 1/41", v2, d2);
        end
        en2 = 1'b0;
        step();
    endtask

    // Extreme values pass bit-exact.
    task automatic test_extremes();
        rdy1 = 1'b1; en1 = 1'b1;
        x1 = -16'sd32768;
        step();
        tests++;
        if (v1 !== 1'b1 || d1 !== -16'sd32768) begin
            fails++;
            $display("FAIL extreme_neg: valid=%b data=%0d, need 1/-32768", v1, d1);
        end
        x1 = 16'sd32767;
        step();
        tests++;
        if (v1 !== 1'b1 || d1 !== 16'sd32767 || lvl1 !== 4'd1) begin
            fails++;
            $display("FAIL extreme_pos: valid=%b data=%0d level=%0d, need 1/32767/1", v1, d1, lvl1);
        end
        en1 = 1'b0;
        step();
        tests++;
        if (v1 !== 1'b0 || lvl1 !== 4'd0) begin
            fails++;
            $display("FAIL extreme_drain: valid=%b level=%0d, need 0/0", v1, lvl1);
        end
    endtask

    initial begin
        test_reset();
        test_decimate();
        test_enable_gating();
        test_overflow();
        test_full_take_pop();
        test_mid_reset();
        test_extremes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
